serial_paralelo_rx: RTL and testbench
=====================================

// Module: serial_paralelo_rx
// PURPOSE
// - Receive-side deserializer for the PHY lane: consumes the 1-bit MSB-first stream driven by the
//   transmit serializer and rebuilds 8-bit symbols in the clk_32f domain.
// - Finds byte alignment by hunting for the COM symbol (8'hBC, which the transmitter sends when idle),
//   then locks after COM_LOCK consecutive aligned COMs.
// - Once aligned, delivers one byte per 8 clocks with a strobe, and flags COM/idle bytes as not valid.
// PARAMETERS
// - COMMA     8'hBC  alignment/idle symbol
// - COM_LOCK  4      consecutive boundary-aligned COMMAs needed to declare lock (legal range 1..15)
// PORTS
// - clk_32f    in   1  bit-rate clock; all logic on posedge
// - reset      in   1  asynchronous, active-high reset
// - data_in    in   1  serial bit, MSB of each byte first
// - resync     in   1  sync pulse; forces the FSM back to SEARCH
// - data_out   out  8  last aligned byte received
// - valid_out  out  1  1 = data_out is a data byte; 0 = data_out is COMMA (idle)
// - byte_stb   out  1  one-cycle pulse when data_out/valid_out update
// - active     out  1  1 while the FSM is ALIGNED
// BEHAVIOUR
// - Reset: asynchronous, active-high, single clock clk_32f.
//   - While reset is high: sr=0, bit_cnt=0, com_cnt=0, state=SEARCH.
//   - All outputs are 0 while reset is high.
// - Every posedge: sr <= {sr[6:0], data_in}. The candidate byte is cand = {sr[6:0], data_in}.
// - FSM states: SEARCH, LOCKING, ALIGNED. bit_cnt is 3 bits, wraps 7->0; com_cnt is 4 bits.
// - SEARCH: check cand==COMMA on every edge (bit-by-bit hunt).
//   - On a match: bit_cnt<=0, com_cnt<=1; go to LOCKING, or go directly to ALIGNED if COM_LOCK==1.
//   - Otherwise: stay in SEARCH.
// - LOCKING: bit_cnt increments each edge. At the edge where bit_cnt==7 (a byte boundary):
//   - cand==COMMA: com_cnt++; when com_cnt+1==COM_LOCK, go to ALIGNED.
//   - cand!=COMMA: com_cnt<=0, go to SEARCH. Only boundary bytes are checked; no re-hunt mid-byte.
// - ALIGNED: at each bit_cnt==7 edge:
//   - data_out<=cand; valid_out<=(cand!=COMMA); byte_stb<=1.
//   - byte_stb is 0 on every other edge. data_out and valid_out hold between strobes.
//   - active is a registered output and reads 1 from the edge after the transition into ALIGNED.
// - Latency: data_out updates on the same edge that samples the byte's LSB.
//   - First ALIGNED strobe comes 8 edges after the locking boundary.
// - ALIGNED is left only via reset or resync. A COMMA in the data stream is legal and gives valid_out=0.
// - resync=1 at an edge takes priority over all FSM actions.
//   - state<=SEARCH, com_cnt<=0; active, byte_stb, valid_out <= 0; data_out holds.
//   - sr still shifts, so a COMMA completing on the edge after resync can be caught.
// - resync in SEARCH: no effect beyond the above.
// - Reset mid-byte or mid-lock: all progress is discarded; a full COM_LOCK sequence is needed to relock.
// TESTING
// - T1: reset 3 cycles, then 0xBC stream at bit offset 3 vs. reset release.
//   - active rises exactly 1 edge after the 4th boundary COMMA.
//   - Strobes then every 8 edges with data_out=BC, valid_out=0.
// - T2: after lock, send A5, 3C, BC.
//   - Strobes in order: {A5,1}, {3C,1}, {BC,0}, spaced 8 edges apart.
//   - active stays 1 throughout.
// - T3: stream BC, BC, 12, BC, ... : the boundary 0x12 returns the FSM to SEARCH.
//   - active stays 0; lock occurs only after 4 fresh COMMAs.
// - T4: stream with a false comma (bit pattern 1011_1100 straddling two data bytes, e.g. 0B,C0).
//   - LOCKING rejects it at the next boundary; final lock lands on the true COMMA phase.
// - T5: assert reset mid-byte while ALIGNED.
//   - All outputs go 0 immediately, with no clock edge needed.
//   - After release: relock after 4 COMMAs, then 0x5A is strobed intact.
// - T6: one-cycle resync pulse while ALIGNED.
//   - active=0 on the next edge; byte_stb stays 0 until relock.
//   - data_out keeps its last value until the next strobe.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
// Receive-side deserializer for the PHY lane. It takes the MSB-first serial
// stream in the clk_32f domain, finds byte alignment by hunting for the COMMA
// symbol, locks after COM_LOCK consecutive boundary-aligned COMMAs, and then
// delivers one byte per 8 clocks with a one-cycle strobe.
//
// Ports
//   clk_32f   in   1  bit-rate clock, all logic on posedge
//   reset     in   1  asynchronous, active-high reset
//   data_in   in   1  serial bit, MSB of each byte first
//   resync    in   1  sync pulse, forces the FSM back to SEARCH
//   data_out  out  8  last aligned byte received
//   valid_out out  1  1 = data byte, 0 = COMMA (idle)
//   byte_stb  out  1  one-cycle pulse when data_out/valid_out update
//   active    out  1  1 while the FSM is ALIGNED (one edge behind the state)
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       resync,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ALIGNED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(COM_LOCK);

    state_t     state_q,   state_d;
    logic [7:0] sr_q,      sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;
    logic       stb_q,     stb_d;
    logic       active_q,  active_d;

    logic [7:0] cand_s;
    logic       is_com_s;
    logic       boundary_s;
    logic [3:0] com_inc_s;

    // Next-state logic: shift register, alignment FSM and output registers.
    always_comb begin
        cand_s     = {sr_q[6:0], data_in};
        is_com_s   = (cand_s == COMMA);
        boundary_s = (bit_cnt_q == 3'd7);
        com_inc_s  = com_cnt_q + 4'd1;

        // The shift register keeps running regardless of resync so that a
        // COMMA completing right after a resync can still be hunted.
        sr_d      = cand_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;
        // active trails the state register by one edge.
        active_d  = (state_q == ST_ALIGNED);

        if (resync) begin
            state_d   = ST_SEARCH;
            com_cnt_d = 4'd0;
            active_d  = 1'b0;
            valid_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    // Bit-by-bit hunt: any phase may match.
                    if (is_com_s) begin
                        bit_cnt_d = 3'd0;
                        com_cnt_d = 4'd1;
                        state_d   = (LOCK_N == 4'd1) ? ST_ALIGNED : ST_LOCKING;
                    end else begin
                        state_d   = ST_SEARCH;
                    end
                end
                ST_LOCKING: begin
                    // Only the byte boundary of the hunted phase is examined.
                    if (boundary_s) begin
                        if (is_com_s) begin
                            com_cnt_d = com_inc_s;
                            state_d   = (com_inc_s == LOCK_N) ? ST_ALIGNED : ST_LOCKING;
                        end else begin
                            com_cnt_d = 4'd0;
                            state_d   = ST_SEARCH;
                        end
                    end else begin
                        state_d   = ST_LOCKING;
                    end
                end
                ST_ALIGNED: begin
                    if (boundary_s) begin
                        data_d  = cand_s;
                        valid_d = ~is_com_s;
                        stb_d   = 1'b1;
                    end else begin
                        stb_d   = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_SEARCH;
                    com_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            sr_q      <= 8'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            active_q  <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign byte_stb  = stb_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Self-checking bench for serial_paralelo_rx. Every edge is compared against a
// behavioural model that tracks the serial window and the locked phase as an
// absolute edge index (boundary = edges since the hunted COMMA divisible by 8).
// Directed sequences cover lock timing, data delivery, false commas, async
// reset and resync; a randomized stream follows.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         NLOCK = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic       resync  = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;

    int total = 0;
    int bad   = 0;

    serial_paralelo_rx #(.COMMA(COM), .COM_LOCK(NLOCK)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .resync   (resync),
        .data_out (data_out),
        .valid_out(valid_out),
        .byte_stb (byte_stb),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    // ---------------- reference model ----------------
    logic [7:0] m_win;
    int         m_mode;      // 0 hunting, 1 counting commas, 2 locked
    int         m_t;         // edges since reset
    int         m_anchor;    // edge at which the hunted COMMA completed
    int         m_n;         // commas seen on the hunted phase
    logic [7:0] m_data;
    logic       m_valid, m_stb, m_active;

    task automatic model_reset();
        m_win = 8'd0; m_mode = 0; m_t = 0; m_anchor = 0; m_n = 0;
        m_data = 8'd0; m_valid = 1'b0; m_stb = 1'b0; m_active = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic rs);
        logic nxt_active;
        m_t++;
        m_win = {m_win[6:0], b};
        nxt_active = (m_mode == 2);
        m_stb = 1'b0;
        if (rs) begin
            m_mode = 0; m_n = 0; nxt_active = 1'b0; m_valid = 1'b0;
        end else if (m_mode == 0) begin
            if (m_win == COM) begin
                m_anchor = m_t; m_n = 1;
                m_mode = (NLOCK == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if ((m_t - m_anchor) % 8 == 0) begin
                if (m_win == COM) begin
                    m_n++;
                    if (m_n == NLOCK) m_mode = 2;
                end else begin
                    m_mode = 0; m_n = 0;
                end
            end
        end else begin
            if ((m_t - m_anchor) % 8 == 0) begin
                m_data = m_win; m_valid = (m_win != COM); m_stb = 1'b1;
            end
        end
        m_active = nxt_active;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"},   data_out,         m_data);
        check({tag, "_valid"},  {7'd0, valid_out}, {7'd0, m_valid});
        check({tag, "_stb"},    {7'd0, byte_stb},  {7'd0, m_stb});
        check({tag, "_active"}, {7'd0, active},    {7'd0, m_active});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data0"},   data_out,          8'd0);
        check({tag, "_valid0"},  {7'd0, valid_out}, 8'd0);
        check({tag, "_stb0"},    {7'd0, byte_stb},  8'd0);
        check({tag, "_active0"}, {7'd0, active},    8'd0);
    endtask

    // One bit per edge; inputs change 1 time unit after the edge.
    task automatic step(input logic b, input logic rs);
        data_in = b;
        resync  = rs;
        @(posedge clk_32f);
        #1;
        model_step(b, rs);
        check_model("edge");
        resync = 1'b0;
    endtask

    task automatic send_from(input logic [7:0] v, input int hi);
        for (int k = hi; k >= 0; k--) step(v[k], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_from(v, 7);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_32f);
            #1;
            check_zero("rst_hold");
        end
        model_reset();
        reset = 1'b0;
    endtask

    task automatic expect_stb(input string tag, input logic [7:0] d, input logic v);
        check({tag, "_stb"},   {7'd0, byte_stb},  8'd1);
        check({tag, "_data"},  data_out,          d);
        check({tag, "_valid"}, {7'd0, valid_out}, {7'd0, v});
    endtask

    // Post-lock data vectors.
    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 8'h3C, 1'b1};
        vecs[2] = '{8'hBC, 8'hBC, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{8'h5A, 8'h5A, 1'b1};
        model_reset();

        // T1: 3-cycle reset, COMMA stream at bit offset 3.
        do_reset(3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < NLOCK; i++) send_byte(COM);
        check("t1_active_pre", {7'd0, active}, 8'd0);
        step(1'b1, 1'b0);
        check("t1_active_rise", {7'd0, active}, 8'd1);
        send_from(COM, 6);
        expect_stb("t1_first", COM, 1'b0);
        send_byte(COM);
        expect_stb("t1_second", COM, 1'b0);

        // T2: data after lock, table-driven.
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].din);
            expect_stb($sformatf("t2_vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid);
            check($sformatf("t2_active%0d", i), {7'd0, active}, 8'd1);
        end

        // T3: a non-COMMA boundary byte during locking restarts the hunt.
        do_reset(2);
        send_byte(COM); send_byte(COM); send_byte(8'h12);
        check("t3_active_after12", {7'd0, active}, 8'd0);
        for (int i = 0; i < NLOCK; i++) send_byte(COM);
        check("t3_active_pre", {7'd0, active}, 8'd0);
        send_byte(COM);
        expect_stb("t3_lock", COM, 1'b0);
        check("t3_active", {7'd0, active}, 8'd1);

        // T4: false comma straddling 0B,C0 must not produce the final phase.
        do_reset(2);
        send_byte(8'h0B); send_byte(8'hC0);
        for (int i = 0; i < 3; i++) send_byte(COM);
        check("t4_active_pre", {7'd0, active}, 8'd0);
        send_byte(COM);
        send_byte(8'h5A);
        expect_stb("t4_data", 8'h5A, 1'b1);
        check("t4_active", {7'd0, active}, 8'd1);

        // T5: asynchronous reset mid-byte while aligned.
        send_from(8'h77, 7);
        send_from(8'h33, 7);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        #2;
        do_reset(2);
        for (int i = 0; i < NLOCK; i++) send_byte(COM);
        send_byte(8'h5A);
        expect_stb("t5_data", 8'h5A, 1'b1);

        // T6: one-cycle resync pulse while aligned.
        send_byte(8'h3C);
        expect_stb("t6_pre", 8'h3C, 1'b1);
        step(1'b1, 1'b1);
        check("t6_active", {7'd0, active}, 8'd0);
        check("t6_stb", {7'd0, byte_stb}, 8'd0);
        check("t6_hold", data_out, 8'h3C);
        send_from(COM, 6);
        for (int i = 0; i < NLOCK - 1; i++) send_byte(COM);
        check("t6_hold2", data_out, 8'h3C);
        check("t6_active_pre", {7'd0, active}, 8'd0);
        send_byte(COM);
        expect_stb("t6_relock", COM, 1'b0);

        // Randomized stream with phase slips and rare resync pulses.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] v;
            if ($urandom_range(0, 9) == 0) step(1'($urandom_range(0, 1)), 1'b0);
            v = ($urandom_range(0, 1) == 1) ? COM : 8'($urandom);
            for (int k = 7; k >= 0; k--) step(v[k], ($urandom_range(0, 149) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
